// File: rtl/param_fifo.sv
// Synchronous FIFO with a DEPTH x DATA_WIDTH circular buffer, a registered read
// port, occupancy flags decoded from the registered count, and one-cycle
// accept/reject pulses for every read and write request.
module param_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = 6,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  wr_ack,
    output logic                  wr_err,
    output logic                  rd_ack,
    output logic                  rd_err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0]         CNT_AF   = CW'(AF_LEVEL);
    localparam logic [CW-1:0]         CNT_AE   = CW'(AE_LEVEL);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  wr_err_q, wr_err_d;
    logic                  rd_ack_q, rd_ack_d;
    logic                  rd_err_q, rd_err_d;

    logic                  rd_accept;
    logic                  wr_accept;
    logic                  mem_we;

    // Flags are a pure decode of the registered occupancy.
    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_AF);
    assign almost_empty = (count_q <= CNT_AE);

    assign data_count = count_q;
    assign dout       = dout_q;
    assign wr_ack     = wr_ack_q;
    assign wr_err     = wr_err_q;
    assign rd_ack     = rd_ack_q;
    assign rd_err     = rd_err_q;

    // Next-state decode: accept/reject requests, advance pointers, track occupancy.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it
        // unassigned; otherwise synthesis would infer a latch to hold its old value.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dout_d    = dout_q;
        wr_ack_d  = 1'b0;
        wr_err_d  = 1'b0;
        rd_ack_d  = 1'b0;
        rd_err_d  = 1'b0;
        mem_we    = 1'b0;

        // A flush overrides both requests; a read frees a slot for a write when full.
        rd_accept = rd_en && !empty && !clr;
        wr_accept = wr_en && (!full || rd_accept) && !clr;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            wr_ack_d = wr_accept;
            wr_err_d = wr_en && !wr_accept;
            rd_ack_d = rd_accept;
            rd_err_d = rd_en && !rd_accept;
            mem_we   = wr_accept;

            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (rd_accept) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                // Read sees pre-edge contents, so a same-edge write to a full
                // FIFO cannot overwrite the entry being returned.
                dout_d   = mem_q[rd_ptr_q];
            end

            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control and output registers, cleared asynchronously by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples
        // pre-edge values, independent of statement order or other always blocks.
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            wr_ack_q <= 1'b0;
            wr_err_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            wr_ack_q <= wr_ack_d;
            wr_err_q <= wr_err_d;
            rd_ack_q <= rd_ack_d;
            rd_err_q <= rd_err_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; stale entries are unreachable because the
        // pointers and count are reset, and leaving it unreset lets it map to RAM.
        if (mem_we) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at default parameters. A queue model predicts
// which reads are accepted and pushes the expected data into a scoreboard; a
// separate monitor pops and compares whenever the DUT pulses rd_ack.
module tb_param_fifo;

    localparam int DW = 32;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic [AW:0]   data_count;
    logic          full, empty, almost_full, almost_empty;
    logic          wr_ack, wr_err, rd_ack, rd_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];

    param_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AF_LEVEL  (6),
        .AE_LEVEL  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .clr         (clr),
        .wr_en       (wr_en),
        .din         (din),
        .rd_en       (rd_en),
        .dout        (dout),
        .data_count  (data_count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .wr_ack      (wr_ack),
        .wr_err      (wr_err),
        .rd_ack      (rd_ack),
        .rd_err      (rd_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_hs(input string name, input logic wa, input logic we,
                          input logic ra, input logic re);
        check({name, ".wr_ack"}, DW'(wr_ack), DW'(wa));
        check({name, ".wr_err"}, DW'(wr_err), DW'(we));
        check({name, ".rd_ack"}, DW'(rd_ack), DW'(ra));
        check({name, ".rd_err"}, DW'(rd_err), DW'(re));
    endtask

    // Expected flags follow from the occupancy with the default 8/6/2 levels.
    task automatic chk_cnt(input string name, input int cnt);
        check({name, ".count"},        DW'(data_count),   DW'(cnt));
        check({name, ".full"},         DW'(full),         DW'(cnt == 8));
        check({name, ".empty"},        DW'(empty),        DW'(cnt == 0));
        check({name, ".almost_full"},  DW'(almost_full),  DW'(cnt >= 6));
        check({name, ".almost_empty"}, DW'(almost_empty), DW'(cnt <= 2));
    endtask

    // Drive one edge's worth of requests and update the reference queue.
    task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic c);
        bit rd_ok;
        bit wr_ok;
        rd_ok = rd && !c && (model_q.size() > 0);
        wr_ok = wr && !c && ((model_q.size() < 8) || rd_ok);
        if (c) model_q.delete();
        if (rd_ok) exp_q.push_back(model_q.pop_front());
        if (wr_ok) model_q.push_back(d);
        wr_en = wr;
        din   = d;
        rd_en = rd;
        clr   = c;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr   = 1'b0;
    endtask

    // Scoreboard monitor: sample mid-cycle, compare read data on every rd_ack.
    always @(negedge clk) begin
        if (reset_n && rd_ack) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_rd_ack", DW'(rd_ack), DW'(0));
            end else begin
                check("sb_dout", dout, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clr     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;

        #12;
        chk_cnt("reset", 0);
        check("reset.dout", dout, 32'h0);
        chk_hs("reset", 0, 0, 0, 0);

        @(negedge clk);
        reset_n = 1'b1;

        // Read from empty after reset.
        step(0, 32'h0, 1, 0);
        chk_hs("rd_empty", 0, 0, 0, 1);
        check("rd_empty.dout", dout, 32'h0);
        chk_cnt("rd_empty", 0);

        // Fill with 1..8, then overflow with 9.
        for (int i = 1; i <= 8; i++) begin
            step(1, DW'(i), 0, 0);
            chk_hs($sformatf("fill%0d", i), 1, 0, 0, 0);
            chk_cnt($sformatf("fill%0d", i), i);
        end
        step(1, 32'h9, 0, 0);
        chk_hs("overflow", 0, 1, 0, 0);
        chk_cnt("overflow", 8);

        // Idle edge: pulses drop.
        step(0, 32'h0, 0, 0);
        chk_hs("idle", 0, 0, 0, 0);

        // Drain 1..8 in order, then underflow holds last data.
        for (int i = 1; i <= 8; i++) begin
            step(0, 32'h0, 1, 0);
            chk_hs($sformatf("drain%0d", i), 0, 0, 1, 0);
            check($sformatf("drain%0d.dout", i), dout, DW'(i));
            chk_cnt($sformatf("drain%0d", i), 8 - i);
        end
        step(0, 32'h0, 1, 0);
        chk_hs("underflow", 0, 0, 0, 1);
        check("underflow.dout", dout, 32'h8);
        chk_cnt("underflow", 0);

        // Refill, then simultaneous read+write while full, then drain across the wrap.
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
        chk_cnt("refill", 8);
        step(1, 32'hA, 1, 0);
        chk_hs("full_rw", 1, 0, 1, 0);
        check("full_rw.dout", dout, 32'h1);
        chk_cnt("full_rw", 8);
        for (int i = 2; i <= 8; i++) begin
            step(0, 32'h0, 1, 0);
            check($sformatf("wrap%0d.dout", i), dout, DW'(i));
        end
        step(0, 32'h0, 1, 0);
        check("wrap_last.dout", dout, 32'hA);
        chk_cnt("wrap_last", 0);

        // Empty with simultaneous read+write: write proceeds, read rejected.
        step(1, 32'h5, 1, 0);
        chk_hs("empty_rw", 1, 0, 0, 1);
        check("empty_rw.dout", dout, 32'hA);
        chk_cnt("empty_rw", 1);

        // Flush with three entries; clr overrides a concurrent write.
        step(1, 32'h6, 0, 0);
        step(1, 32'h7, 0, 0);
        chk_cnt("pre_clr", 3);
        step(1, 32'hEE, 1, 1);
        chk_hs("clr", 0, 0, 0, 0);
        check("clr.dout", dout, 32'hA);
        chk_cnt("clr", 0);
        step(0, 32'h0, 1, 0);
        chk_hs("post_clr_rd", 0, 0, 0, 1);

        // Mid-burst asynchronous reset, asserted between clock edges.
        step(1, 32'h11, 0, 0);
        step(1, 32'h22, 0, 0);
        step(0, 32'h0, 1, 0);
        step(1, 32'h33, 0, 0);
        check("pre_rst.dout", dout, 32'h11);
        #2;
        reset_n = 1'b0;
        model_q.delete();
        #1;
        chk_cnt("async_rst", 0);
        check("async_rst.dout", dout, 32'h0);
        chk_hs("async_rst", 0, 0, 0, 0);

        @(negedge clk);
        reset_n = 1'b1;
        step(0, 32'h0, 1, 0);
        chk_hs("post_rst_rd", 0, 0, 0, 1);
        chk_cnt("post_rst_rd", 0);
        step(1, 32'h44, 0, 0);
        step(0, 32'h0, 1, 0);
        check("post_rst.dout", dout, 32'h44);
        chk_cnt("post_rst", 0);

        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", DW'(exp_q.size()), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_WIDTH, 32, data bus width in bits (>=1)
  ADDR_WIDTH, 3, address width; DEPTH = 2**ADDR_WIDTH entries
  AF_LEVEL, 6, almost_full asserts when data_count >= AF_LEVEL
  AE_LEVEL, 2, almost_empty asserts when data_count <= AE_LEVEL
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  single clock, all state on rising edge
  reset_n  in  1  asynchronous active-low reset
  clr  in  1  synchronous flush, active-high
  wr_en  in  1  write request
  din  in  DATA_WIDTH  write data
  rd_en  in  1  read request
  dout  out  DATA_WIDTH  registered read data
  data_count  out  ADDR_WIDTH+1  entries held, 0..DEPTH
  full  out  1  data_count == DEPTH
  empty  out  1  data_count == 0
  almost_full  out  1  data_count >= AF_LEVEL
  almost_empty  out  1  data_count <= AE_LEVEL
  wr_ack  out  1  write accepted last edge
  wr_err  out  1  write rejected last edge
  rd_ack  out  1  read performed last edge
  rd_err  out  1  read rejected last edge
REQ-003 One clock (clk); reset_n SHALL be asynchronous and active-low; no other reset polarity or synchronicity is permitted.

Function
REQ-004 Storage SHALL be DEPTH x DATA_WIDTH, circular, with ADDR_WIDTH-bit write and read pointers wrapping DEPTH-1 -> 0.
REQ-005 data_count, pointers, dout and all handshake outputs SHALL be registers; full/empty/almost flags SHALL be a combinational decode of registered data_count.
REQ-006 Write accepted iff wr_en=1 and (full=0 or a read is accepted the same edge): din stored at wr_ptr, wr_ptr increments, wr_ack=1 next cycle.
REQ-007 Write with wr_en=1, full=1, no accepted read: memory, wr_ptr unchanged, wr_err=1 next cycle.
REQ-008 Read accepted iff rd_en=1 and empty=0: dout <= mem[rd_ptr], rd_ptr increments, rd_ack=1 next cycle; read latency one edge.
REQ-009 Read with rd_en=1, empty=1: dout holds, rd_ptr unchanged, rd_err=1 next cycle; a simultaneous write still proceeds per REQ-006.
REQ-010 data_count: +1 write only, -1 read only, unchanged both or neither; never exceeds DEPTH nor goes below 0.
REQ-011 Simultaneous accepted read and write when full: read returns oldest entry (pre-edge contents), write fills freed slot, full stays 1.
REQ-012 Each handshake output SHALL be a one-cycle pulse per request edge, deasserted when the corresponding enable is 0; wr_ack/wr_err mutually exclusive, rd_ack/rd_err mutually exclusive.
REQ-013 dout SHALL hold its last value whenever no read is accepted.
REQ-014 clr=1 at an edge SHALL zero pointers and data_count, clear handshake outputs, hold dout; clr overrides wr_en/rd_en that edge.

Reset
REQ-015 reset_n=0 SHALL immediately, independent of clk, force pointers=0, data_count=0, dout=0, all handshake outputs=0; thus empty=1, almost_empty=1, full=0, almost_full=0.
REQ-016 Reset asserted mid-operation SHALL discard contents; first edge after release behaves as empty FIFO.
REQ-017 Memory contents need not be reset.

Verification
REQ-018 Reset then rd_en=1 one cycle -> rd_err=1, rd_ack=0, dout=0, data_count=0.
REQ-019 Defaults: write 1..8 consecutively -> wr_ack each cycle, data_count 1..8, almost_full at count 6, full at 8; 9th write (0x9) -> wr_err=1, count stays 8.
REQ-020 From full, rd_en 8 cycles -> dout 1..8 in order, one edge after each rd_en, almost_empty at count 2, empty at 0; 9th read -> rd_err=1, dout holds 8.
REQ-021 Full, rd_en=wr_en=1 din=0xA -> dout=1, wr_ack=rd_ack=1, count 8; subsequent drain ends with 0xA (wrap verified).
REQ-022 Empty, rd_en=wr_en=1 din=0x5 -> wr_ack=1, rd_err=1, count 1; clr with 3 entries -> count 0, empty=1, dout held; reset_n pulsed mid-burst asynchronously -> all outputs per REQ-015 before next clk edge.
